cola_trabajos: RTL and testbench

Job scheduler for the printer/scanner. Captures `imprimir` and `escanear` requests from the front panel into a small job queue, arbitrates simultaneous requests, and sequences the shared engine one job at a time. For print jobs it tracks per-cartridge ink, stalling on an empty cartridge until a refill. It sits between the panel inputs and the engine/display logic; its `fin_*` and `esc_escaner` outputs drive the same indicators the top level already exposes.

---
 rtl/impresora_pkg.sv | 23 ++
 rtl/fifo_trabajos.sv | 71 +++++++
 rtl/cola_trabajos.sv | 189 ++++++++++++++++++
 tb/tb_cola_trabajos.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/impresora_pkg.sv
// Shared types for the printer/scanner job scheduler.
package impresora_pkg;

    // Job-sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StPrint,
        StWaitInk,
        StDone
    } estado_t;

    // One queued job: {tipo, color, paginas}.
    typedef struct packed {
        logic       tipo;
        logic       color;
        logic [1:0] paginas;
    } trabajo_t;

    localparam logic TIPO_ESCANEO   = 1'b0;
    localparam logic TIPO_IMPRESION = 1'b1;

endpackage

// File: rtl/fifo_trabajos.sv
// Job FIFO: up to two pushes per cycle (a before b) and one pop, first-word fall-through.
module fifo_trabajos #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   push_a_i,
    input  logic [WIDTH-1:0]       data_a_i,
    input  logic                   push_b_i,
    input  logic [WIDTH-1:0]       data_b_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_pop;

    // Next-state: writes land in order at the write pointer; caller guarantees space.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        do_pop  = pop_i && (count_q != '0);
        if (push_a_i) begin
            mem_d[wptr_d] = data_a_i;
            wptr_d        = wptr_d + 1'b1;
        end
        if (push_b_i) begin
            mem_d[wptr_d] = data_b_i;
            wptr_d        = wptr_d + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        count_d = count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(do_pop);
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign rd_data_o = mem_q[rptr_q];
    assign count_o   = count_q;
    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/cola_trabajos.sv
// Printer/scanner job scheduler: request capture, arbitration, job sequencing, ink tracking.
module cola_trabajos
    import impresora_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SCAN_CYCLES = 6,
    parameter int unsigned PAGE_CYCLES = 4,
    parameter int unsigned INK_MAX     = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       prendido,
    input  logic       imprimir,
    input  logic       escanear,
    input  logic       color,
    input  logic [1:0] paginas,
    input  logic       rellenar_color,
    input  logic       rellenar_negro,
    output logic       esc_escaner,
    output logic       imp_color,
    output logic       imp_negro,
    output logic       fin_color,
    output logic       fin_negro,
    output logic       lleno,
    output logic       rechazo,
    output logic       trabajo_fin,
    output logic [2:0] paginas_rest
);

    localparam int unsigned IW      = $clog2(INK_MAX + 1);
    localparam int unsigned CNT_MAX = (SCAN_CYCLES > PAGE_CYCLES) ? SCAN_CYCLES : PAGE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int unsigned FCW     = $clog2(DEPTH) + 1;

    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pag_q, pag_d;
    logic             col_q, col_d;
    logic [IW-1:0]    ink_c_q, ink_c_d;
    logic [IW-1:0]    ink_n_q, ink_n_d;
    logic             rechazo_q, rechazo_d;

    trabajo_t         cabeza;
    trabajo_t         ent_scan, ent_print;
    logic [FCW-1:0]   f_count;
    logic             f_full, f_empty;
    logic             pop, push_scan, push_print;
    logic             fin_pagina;
    int               libres;

    assign ent_scan  = '{tipo: TIPO_ESCANEO, color: 1'b0, paginas: 2'b00};
    assign ent_print = '{tipo: TIPO_IMPRESION, color: color, paginas: paginas};

    fifo_trabajos #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(trabajo_t))
    ) u_fifo (
        .clk_i     (clk),
        .reset_i   (reset),
        .push_a_i  (push_scan),
        .data_a_i  (ent_scan),
        .push_b_i  (push_print),
        .data_b_i  (ent_print),
        .pop_i     (pop),
        .rd_data_o (cabeza),
        .count_o   (f_count),
        .full_o    (f_full),
        .empty_o   (f_empty)
    );

    assign fin_pagina = (estado_q == StPrint) && (cnt_q == CNT_W'(PAGE_CYCLES - 1));

    // Arbitration: a slot freed by this cycle's pop is usable; scan claims space before print.
    always_comb begin
        libres     = int'(DEPTH) - int'(f_count) + (pop ? 1 : 0);
        push_scan  = prendido && escanear && (libres >= 1);
        push_print = prendido && imprimir && (libres >= (push_scan ? 2 : 1));
        rechazo_d  = prendido && ((escanear && !push_scan) || (imprimir && !push_print));
    end

    // Ink levels: one unit per finished page, saturating at zero; a refill overrides.
    always_comb begin
        ink_c_d = ink_c_q;
        ink_n_d = ink_n_q;
        if (fin_pagina && col_q && (ink_c_q != '0)) begin
            ink_c_d = ink_c_q - 1'b1;
        end
        if (fin_pagina && !col_q && (ink_n_q != '0)) begin
            ink_n_d = ink_n_q - 1'b1;
        end
        if (rellenar_color) begin
            ink_c_d = IW'(INK_MAX);
        end
        if (rellenar_negro) begin
            ink_n_d = IW'(INK_MAX);
        end
    end

    // Job sequencer; page-start ink checks look at the post-edge level so a same-cycle
    // refill avoids a needless stall.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        pag_d    = pag_q;
        col_d    = col_q;
        pop      = 1'b0;
        unique case (estado_q)
            StIdle: begin
                if (prendido && !f_empty) begin
                    pop   = 1'b1;
                    cnt_d = '0;
                    if (cabeza.tipo == TIPO_ESCANEO) begin
                        estado_d = StScan;
                    end else begin
                        col_d    = cabeza.color;
                        pag_d    = {1'b0, cabeza.paginas} + 3'd1;
                        estado_d = ((cabeza.color ? ink_c_d : ink_n_d) == '0) ? StWaitInk
                                                                               : StPrint;
                    end
                end
            end
            StScan: begin
                if (cnt_q == CNT_W'(SCAN_CYCLES - 1)) begin
                    cnt_d    = '0;
                    estado_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPrint: begin
                if (fin_pagina) begin
                    cnt_d = '0;
                    pag_d = pag_q - 3'd1;
                    if (pag_q == 3'd1) begin
                        estado_d = StDone;
                    end else if ((col_q ? ink_c_d : ink_n_d) == '0) begin
                        estado_d = StWaitInk;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitInk: begin
                if (col_q ? rellenar_color : rellenar_negro) begin
                    cnt_d    = '0;
                    estado_d = StPrint;
                end
            end
            StDone: begin
                estado_d = StIdle;
            end
            default: begin
                estado_d = StIdle;
            end
        endcase
    end

    // State registers; reset leaves both cartridges full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= StIdle;
            cnt_q     <= '0;
            pag_q     <= '0;
            col_q     <= 1'b0;
            ink_c_q   <= IW'(INK_MAX);
            ink_n_q   <= IW'(INK_MAX);
            rechazo_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            pag_q     <= pag_d;
            col_q     <= col_d;
            ink_c_q   <= ink_c_d;
            ink_n_q   <= ink_n_d;
            rechazo_q <= rechazo_d;
        end
    end

    assign esc_escaner  = (estado_q == StScan);
    assign imp_color    = (estado_q == StPrint) && col_q;
    assign imp_negro    = (estado_q == StPrint) && !col_q;
    assign fin_color    = (ink_c_q == '0);
    assign fin_negro    = (ink_n_q == '0);
    assign lleno        = f_full;
    assign rechazo      = rechazo_q;
    assign trabajo_fin  = (estado_q == StDone);
    assign paginas_rest = pag_q;

endmodule

// File: tb/tb_cola_trabajos.sv
// Bench for cola_trabajos: directed scenarios plus random traffic against a job-level model.
module tb_cola_trabajos;

    localparam int DEPTH = 4;
    localparam int SCAN  = 6;
    localparam int PAGE  = 4;
    localparam int INK   = 7;

    localparam int K_IDLE  = 0;
    localparam int K_SCAN  = 1;
    localparam int K_PRINT = 2;
    localparam int K_WAIT  = 3;
    localparam int K_DONE  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       prendido, imprimir, escanear, color;
    logic [1:0] paginas;
    logic       rellenar_color, rellenar_negro;
    logic       esc_escaner, imp_color, imp_negro, fin_color, fin_negro;
    logic       lleno, rechazo, trabajo_fin;
    logic [2:0] paginas_rest;
    logic [15:0] obs;

    int checks = 0;
    int errors = 0;
    string fase = "reset";

    // Reference model state.
    int         m_kind, m_left, m_pages, m_inkc, m_inkn;
    bit         m_col, m_rej;
    logic [3:0] m_q[$];

    cola_trabajos #(
        .DEPTH       (DEPTH),
        .SCAN_CYCLES (SCAN),
        .PAGE_CYCLES (PAGE),
        .INK_MAX     (INK)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .prendido       (prendido),
        .imprimir       (imprimir),
        .escanear       (escanear),
        .color          (color),
        .paginas        (paginas),
        .rellenar_color (rellenar_color),
        .rellenar_negro (rellenar_negro),
        .esc_escaner    (esc_escaner),
        .imp_color      (imp_color),
        .imp_negro      (imp_negro),
        .fin_color      (fin_color),
        .fin_negro      (fin_negro),
        .lleno          (lleno),
        .rechazo        (rechazo),
        .trabajo_fin    (trabajo_fin),
        .paginas_rest   (paginas_rest)
    );

    always #5 clk = ~clk;

    assign obs = {5'b0, esc_escaner, imp_color, imp_negro, fin_color, fin_negro,
                  lleno, rechazo, trabajo_fin, paginas_rest};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got %b want %b", tag, $time, got, want);
        end
    endtask

    function automatic logic [15:0] expected();
        return {5'b0, 1'(m_kind == K_SCAN), 1'(m_kind == K_PRINT && m_col),
                1'(m_kind == K_PRINT && !m_col), 1'(m_inkc == 0), 1'(m_inkn == 0),
                1'(m_q.size() == DEPTH), m_rej, 1'(m_kind == K_DONE), 3'(m_pages)};
    endfunction

    task automatic model_reset();
        m_kind  = K_IDLE;
        m_left  = 0;
        m_pages = 0;
        m_inkc  = INK;
        m_inkn  = INK;
        m_col   = 0;
        m_rej   = 0;
        m_q.delete();
    endtask

    // One clock edge of the scheduler at job level.
    task automatic model_step();
        logic [3:0] head;
        bit pop, s_ok, p_ok, page_end;
        int free, nic, inn, nk, nleft, npages;
        bit ncol;
        nk = m_kind; nleft = m_left; npages = m_pages; ncol = m_col;
        nic = m_inkc; inn = m_inkn;
        head = 4'b0;
        pop = (m_kind == K_IDLE) && prendido && (m_q.size() > 0);
        page_end = (m_kind == K_PRINT) && (m_left == 1);
        if (page_end && m_col && nic > 0) nic--;
        if (page_end && !m_col && inn > 0) inn--;
        if (rellenar_color) nic = INK;
        if (rellenar_negro) inn = INK;
        case (m_kind)
            K_IDLE: if (pop) begin
                head = m_q[0];
                if (!head[3]) begin
                    nk = K_SCAN; nleft = SCAN;
                end else begin
                    ncol = head[2]; npages = int'(head[1:0]) + 1; nleft = PAGE;
                    nk = (((ncol ? nic : inn)) == 0) ? K_WAIT : K_PRINT;
                end
            end
            K_SCAN: begin
                nleft--;
                if (nleft == 0) nk = K_DONE;
            end
            K_PRINT: if (page_end) begin
                npages--; nleft = PAGE;
                if (npages == 0) nk = K_DONE;
                else if ((m_col ? nic : inn) == 0) nk = K_WAIT;
            end else begin
                nleft--;
            end
            K_WAIT: if (m_col ? rellenar_color : rellenar_negro) begin
                nk = K_PRINT; nleft = PAGE;
            end
            default: nk = K_IDLE;
        endcase
        if (pop) void'(m_q.pop_front());
        free = DEPTH - m_q.size();
        s_ok = prendido && escanear && free >= 1;
        if (s_ok) begin m_q.push_back(4'b0000); free--; end
        p_ok = prendido && imprimir && free >= 1;
        if (p_ok) m_q.push_back({1'b1, color, paginas});
        m_rej = prendido && ((escanear && !s_ok) || (imprimir && !p_ok));
        m_kind = nk; m_left = nleft; m_pages = npages; m_col = ncol;
        m_inkc = nic; m_inkn = inn;
    endtask

    task automatic drive(input bit pr, input bit es, input bit im, input bit co,
                         input bit [1:0] pg, input bit rc, input bit rn);
        prendido = pr; escanear = es; imprimir = im; color = co; paginas = pg;
        rellenar_color = rc; rellenar_negro = rn;
        @(posedge clk);
        model_step();
        #1;
        check(fase, obs, expected());
    endtask

    task automatic idle(input int n, input bit pr);
        for (int i = 0; i < n; i++) drive(pr, 0, 0, 0, 2'b00, 0, 0);
    endtask

    // Reset asserted between edges must clear outputs without waiting for a clock.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async_reset", obs, expected());
        #2 reset = 1'b0;
    endtask

    initial begin
        bit pr_r;
        reset = 1'b1;
        prendido = 0; escanear = 0; imprimir = 0; color = 0; paginas = 2'b00;
        rellenar_color = 0; rellenar_negro = 0;
        model_reset();
        #12;
        check("reset", obs, expected());
        reset = 1'b0;

        fase = "scan";
        drive(1, 1, 0, 0, 2'b00, 0, 0);
        idle(10, 1);

        fase = "print_color";
        drive(1, 0, 1, 1, 2'b01, 0, 0);
        idle(12, 1);

        fase = "black_stall";
        drive(1, 0, 1, 0, 2'b11, 0, 0);
        drive(1, 0, 1, 0, 2'b11, 0, 0);
        idle(40, 1);
        drive(1, 0, 0, 0, 2'b00, 0, 1);
        idle(10, 1);

        fase = "full_drop";
        drive(1, 0, 1, 1, 2'b11, 0, 0);
        drive(1, 1, 0, 0, 2'b00, 0, 0);
        drive(1, 1, 0, 0, 2'b00, 0, 0);
        drive(1, 1, 0, 0, 2'b00, 0, 0);
        drive(1, 1, 1, 0, 2'b10, 0, 0);
        drive(1, 1, 0, 0, 2'b00, 0, 0);
        idle(60, 1);

        fase = "mid_reset";
        drive(1, 0, 1, 0, 2'b11, 0, 0);
        idle(4, 1);
        async_reset();
        fase = "after_reset";
        drive(1, 1, 0, 0, 2'b00, 0, 0);
        idle(10, 1);

        fase = "power_off";
        drive(1, 0, 1, 0, 2'b01, 0, 0);
        drive(1, 1, 0, 0, 2'b00, 0, 0);
        drive(1, 1, 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < 30; i++) begin
            drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 2'b00, 0, 0);
        end
        idle(30, 1);

        fase = "random";
        pr_r = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) pr_r = !pr_r;
            drive(pr_r, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 29) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
